// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate L1 data-cache controller with a 256-bit line memory port.
// Optional hit/miss counters are enabled by defining DCACHE_STATS_EN.
module dcache_controller #(
  parameter int unsigned NUM_LINES = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         cpu_req_i,
  input  logic         cpu_write_i,
  input  logic [31:0]  cpu_addr_i,
  input  logic [31:0]  cpu_data_i,
  output logic [31:0]  cpu_data_o,
  output logic         cpu_stall_o,
  output logic         mem_enable_o,
  output logic         mem_write_o,
  output logic [31:0]  mem_addr_o,
  output logic [255:0] mem_data_o,
  input  logic [255:0] mem_data_i,
  input  logic         mem_ack_i
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]  hit_count_o,
  output logic [31:0]  miss_count_o
`endif
);

  localparam int unsigned LINE_BITS = 256;
  localparam int unsigned IDX_W     = $clog2(NUM_LINES);
  localparam int unsigned TAG_W     = 32 - 5 - IDX_W;

  typedef enum logic [1:0] {S_IDLE, S_WRITEBACK, S_ALLOCATE} state_e;

  state_e               state_q, state_d;
  logic [TAG_W-1:0]     tag_q   [NUM_LINES];
  logic [LINE_BITS-1:0] data_q  [NUM_LINES];
  logic [NUM_LINES-1:0] valid_q, dirty_q;
  logic [TAG_W-1:0]     lat_tag_q;
  logic [IDX_W-1:0]     lat_idx_q;

  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;
  logic [2:0]       req_word;
  logic             hit, idle, miss_start, store_hit, fill_done, wb_done;
  logic             unused_addr;

  assign req_idx     = cpu_addr_i[5 +: IDX_W];
  assign req_tag     = cpu_addr_i[31 -: TAG_W];
  assign req_word    = cpu_addr_i[4:2];
  assign unused_addr = ^cpu_addr_i[1:0];

  assign idle        = (state_q == S_IDLE);
  assign hit         = cpu_req_i & valid_q[req_idx] & (tag_q[req_idx] == req_tag);
  assign cpu_stall_o = cpu_req_i & ~(idle & hit);
  assign miss_start  = idle & cpu_req_i & ~hit;
  assign store_hit   = idle & hit & cpu_write_i;
  assign fill_done   = (state_q == S_ALLOCATE) & mem_ack_i;
  assign wb_done     = (state_q == S_WRITEBACK) & mem_ack_i;
  assign cpu_data_o  = data_q[req_idx][{req_word, 5'b0} +: 32];

  // State register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (miss_start) begin
          state_d = (valid_q[req_idx] & dirty_q[req_idx]) ? S_WRITEBACK : S_ALLOCATE;
        end
      end
      S_WRITEBACK: if (mem_ack_i) state_d = S_ALLOCATE;
      S_ALLOCATE:  if (mem_ack_i) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // Memory-port outputs decoded from the current state
  always_comb begin
    mem_enable_o = 1'b0;
    mem_write_o  = 1'b0;
    mem_addr_o   = 32'h0;
    mem_data_o   = '0;
    unique case (state_q)
      S_WRITEBACK: begin
        mem_enable_o = 1'b1;
        mem_write_o  = 1'b1;
        mem_addr_o   = {tag_q[lat_idx_q], lat_idx_q, 5'b0};
        mem_data_o   = data_q[lat_idx_q];
      end
      S_ALLOCATE: begin
        mem_enable_o = 1'b1;
        mem_addr_o   = {lat_tag_q, lat_idx_q, 5'b0};
      end
      default: ;
    endcase
  end

  // Valid/dirty bits and the latched miss address
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_q   <= '0;
      dirty_q   <= '0;
      lat_tag_q <= '0;
      lat_idx_q <= '0;
    end else begin
      if (miss_start) begin
        lat_tag_q <= req_tag;
        lat_idx_q <= req_idx;
      end
      if (wb_done) dirty_q[lat_idx_q] <= 1'b0;
      if (fill_done) begin
        valid_q[lat_idx_q] <= 1'b1;
        dirty_q[lat_idx_q] <= 1'b0;
      end
      if (store_hit) dirty_q[req_idx] <= 1'b1;
    end
  end

  // Tag and data arrays carry no reset; valid bits guard them
  always_ff @(posedge clk_i) begin
    if (fill_done) begin
      data_q[lat_idx_q] <= mem_data_i;
      tag_q[lat_idx_q]  <= lat_tag_q;
    end
    if (store_hit) data_q[req_idx][{req_word, 5'b0} +: 32] <= cpu_data_i;
  end

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;
  logic        refill_q;

  // refill_q marks the completion cycle of a miss so it is not counted as a hit
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      hit_cnt_q  <= 32'h0;
      miss_cnt_q <= 32'h0;
      refill_q   <= 1'b0;
    end else begin
      if (fill_done)                 refill_q   <= 1'b1;
      else if (idle)                 refill_q   <= 1'b0;
      if (idle & hit & ~refill_q)    hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (miss_start)                miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_count_o  = hit_cnt_q;
  assign miss_count_o = miss_cnt_q;
`endif

endmodule

// File: doc/dcache_controller.md
Name: dcache_controller

Overview:
- L1 data-cache controller for the MEM stage: direct-mapped, write-back, write-allocate.
- Holds tag/valid/dirty and line data internally and serves CPU load/store requests.
- Drives cpu_stall_o, which freezes PC, the IF/ID, ID/EX and EX/MEM registers, and the MEM/WB register's stall_i.
- Talks to the off-chip data memory over a 256-bit enable/ack line interface.

Parameters:
- NUM_LINES, 16, number of cache lines; power of two, minimum 2.
- LINE_BITS, 256, line width in bits (32 bytes, 8 words); fixed, not to be overridden.

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous reset, active-low
- cpu_req_i  in  1  CPU access request (load or store) this cycle
- cpu_write_i  in  1  1 = store, 0 = load; valid with cpu_req_i
- cpu_addr_i  in  32  byte address; word-aligned, bits [1:0] ignored
- cpu_data_i  in  32  store data
- cpu_data_o  out  32  load data; valid when cpu_req_i=1 and cpu_stall_o=0
- cpu_stall_o  out  1  1 = access not complete, hold pipeline
- mem_enable_o  out  1  memory request, held until acknowledged
- mem_write_o  out  1  1 = line write-back, 0 = line fetch
- mem_addr_o  out  32  line-aligned memory address, bits [4:0]=0
- mem_data_o  out  256  write-back line data
- mem_data_i  in  256  fetched line data, valid with mem_ack_i
- mem_ack_i  in  1  one-cycle completion pulse from memory

Behaviour:
- Address split: offset = addr[4:0]; word select = addr[4:2]; index = addr[4+log2(NUM_LINES):5]; tag = remaining upper bits.
- hit = cpu_req_i & valid[index] & (tag match). Combinational.
- cpu_stall_o = cpu_req_i & ~(state==IDLE & hit). Combinational.
- Load hit: cpu_data_o = selected word, same cycle, no stall. cpu_data_o is don't-care otherwise; the RTL drives the selected word of the indexed line.
- Store hit: on the clock edge, write cpu_data_i into the selected word and set dirty[index]=1. No stall.
- FSM states: IDLE, WRITEBACK, ALLOCATE.
- IDLE:
  - On cpu_req_i & ~hit: go to WRITEBACK if valid & dirty, else go to ALLOCATE.
  - The request address (index/tag) is latched in this same cycle.
- WRITEBACK:
  - mem_enable_o=1, mem_write_o=1.
  - mem_addr_o = {stored tag, index, 5'b0}; mem_data_o = line data.
  - On mem_ack_i: clear dirty and go to ALLOCATE.
- ALLOCATE:
  - mem_enable_o=1, mem_write_o=0, mem_addr_o = {latched tag, index, 5'b0}.
  - On mem_ack_i: line <= mem_data_i, tag <= latched tag, valid=1, dirty=0; go to IDLE.
- Miss completion: the cycle after returning to IDLE the access hits and completes with stall low. A store miss performs its word write in that hit cycle.
- Miss latency:
  - Clean miss: 1 + (cycles until ack) + 1 cycles of stall.
  - Dirty miss: adds the write-back handshake.
- Memory handshake:
  - mem_enable_o, mem_write_o, mem_addr_o and mem_data_o stay stable while enable is high.
  - mem_enable_o drops in the cycle after ack because the state has changed.
  - Back-to-back WRITEBACK then ALLOCATE: enable drops for zero cycles; the address and write flag change on the same edge.
- mem_ack_i in IDLE is ignored.
- cpu_req_i deasserting mid-miss: the in-flight fill still completes, the line is installed, and the FSM returns to IDLE.
- cpu_addr_i changing mid-miss: ignored; the latched address is used.
- Reset (asynchronous, any state, including mid-handshake):
  - State=IDLE; all valid=0, dirty=0; mem_enable_o=0, mem_write_o=0, mem_addr_o=0, mem_data_o=0.
  - Latched address=0.
  - During and after reset, cpu_stall_o = cpu_req_i, since every access misses.
  - Data and tag arrays are not reset.

Optional Feature:
- Macro: DCACHE_STATS_EN.
- Defined: adds outputs hit_count_o[31:0] and miss_count_o[31:0], both reset to 0 by rst_i.
  - hit_count_o increments once per completed access that hit without entering the miss FSM.
  - miss_count_o increments once per IDLE->WRITEBACK/ALLOCATE transition.
  - Both wrap at 2^32.
- Undefined: neither the ports nor the counters exist.

Test Plan:
- Reset, then load 0x0000_0040 -> stall=1; ALLOCATE with mem_addr_o=0x40, mem_write_o=0. Return mem_data_i word2=0xDEAD_BEEF and read 0x48 -> after ack, one cycle later stall=0 and cpu_data_o=0xDEAD_BEEF.
- Store 0x1234_5678 to 0x44 (hit), then load 0x44 -> no stall on either access; load returns 0x1234_5678.
- With 0x40 dirty and NUM_LINES=16, load 0x240 (same index, new tag) -> WRITEBACK with mem_addr_o=0x40, mem_write_o=1 and mem_data_o carrying 0x1234_5678 in word1; then ALLOCATE with mem_addr_o=0x240.
- Store miss to 0x80, value 0xA5A5_A5A5 -> fill, then word written; a later eviction writes back a line containing 0xA5A5_A5A5.
- Assert rst_i=0 while in ALLOCATE with ack pending -> mem_enable_o=0 immediately; a later load to the same address misses again.
- With DCACHE_STATS_EN defined, run the sequence above -> hit_count_o and miss_count_o match the hand-counted totals.
